// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - slot/state types, channel map and smoothing helper for pot_scan_sched
package eq_pkg;

  localparam int NUM_POTS = 6;

  typedef enum logic [2:0] {
    SLOT_LP  = 3'd0,
    SLOT_B1  = 3'd1,
    SLOT_B2  = 3'd2,
    SLOT_B3  = 3'd3,
    SLOT_HP  = 3'd4,
    SLOT_VOL = 3'd5
  } slot_e;

  typedef enum logic [2:0] {
    ST_GAP   = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STORE = 3'd3,
    ST_NEXT  = 3'd4
  } state_e;

  // ADC channel wired to each slot, indexed by slot_e
  localparam logic [2:0] POT_CHNL_MAP [NUM_POTS] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  function automatic logic [11:0] pot_smooth(input logic [11:0] old_val,
                                             input logic [11:0] new_val);
    logic [13:0] acc;
    acc = ({2'b00, old_val} * 14'd3) + {2'b00, new_val} + 14'd2;
    return acc[13:2];
  endfunction

endpackage

// File: rtl/pot_scan_sched.sv
// rtl/pot_scan_sched.sv - round-robin A2D scheduler for the six equalizer pots
// Optional IIR smoothing of stored results when POT_SMOOTH_EN is defined.
module pot_scan_sched
  import eq_pkg::*;
#(
  parameter int SCAN_GAP = 1024,
  parameter int TIMEOUT  = 4096,
  parameter int CNT_W    = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        a2d_strt,
  output logic [2:0]  a2d_chnl,
  input  logic        a2d_cmplt,
  input  logic [11:0] a2d_res,
  output logic [11:0] lp_pot,
  output logic [11:0] b1_pot,
  output logic [11:0] b2_pot,
  output logic [11:0] b3_pot,
  output logic [11:0] hp_pot,
  output logic [11:0] vol_pot,
  output logic        pots_vld,
  output logic        sweep_done,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(SCAN_GAP - 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  slot_e              slot_q, slot_d, slot_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               skip_q, skip_d;
  logic               strt_q, strt_d;
  logic [2:0]         chnl_q, chnl_d;
  logic               sweep_q, sweep_d;
  logic               tmo_q, tmo_d;
  logic [11:0]        res_q, res_d;
  logic [11:0]        pot_q [NUM_POTS];
  logic [NUM_POTS-1:0] written_q;
  logic               vld_q;
  logic [11:0]        store_val;

  assign slot_inc = slot_e'(slot_q + 3'd1);

  // skip_q lets a fresh reset or a mid-sweep park start on the first enabled cycle
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    strt_d  = 1'b0;
    chnl_d  = chnl_q;
    sweep_d = 1'b0;
    tmo_d   = tmo_q;
    res_d   = res_q;
    unique case (state_q)
      ST_GAP: begin
        if (cnt_q != GAP_MAX) cnt_d = cnt_q + 1'b1;
        if (en && (skip_q || cnt_q == GAP_MAX)) begin
          state_d = ST_START;
          cnt_d   = '0;
          skip_d  = 1'b0;
          strt_d  = 1'b1;
          chnl_d  = POT_CHNL_MAP[slot_q];
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (a2d_cmplt) begin
          res_d   = a2d_res;
          state_d = ST_STORE;
        end else if (cnt_q == TO_MAX) begin
          tmo_d   = 1'b1;
          state_d = ST_NEXT;
          sweep_d = (slot_q == SLOT_VOL);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STORE: begin
        state_d = ST_NEXT;
        sweep_d = (slot_q == SLOT_VOL);
      end
      ST_NEXT: begin
        if (slot_q == SLOT_VOL) begin
          slot_d  = SLOT_LP;
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          slot_d = slot_inc;
          if (en) begin
            state_d = ST_START;
            cnt_d   = '0;
            strt_d  = 1'b1;
            chnl_d  = POT_CHNL_MAP[slot_inc];
          end else begin
            state_d = ST_GAP;
            skip_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_GAP;
    endcase
  end

`ifdef POT_SMOOTH_EN
  assign store_val = written_q[slot_q] ? pot_smooth(pot_q[slot_q], res_q) : res_q;
`else
  assign store_val = res_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_GAP;
      slot_q    <= SLOT_LP;
      cnt_q     <= '0;
      skip_q    <= 1'b1;
      strt_q    <= 1'b0;
      chnl_q    <= POT_CHNL_MAP[SLOT_LP];
      sweep_q   <= 1'b0;
      tmo_q     <= 1'b0;
      res_q     <= '0;
      written_q <= '0;
      vld_q     <= 1'b0;
      for (int i = 0; i < NUM_POTS; i++) pot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      strt_q  <= strt_d;
      chnl_q  <= chnl_d;
      sweep_q <= sweep_d;
      tmo_q   <= tmo_d;
      res_q   <= res_d;
      if (state_q == ST_STORE) begin
        pot_q[slot_q]     <= store_val;
        written_q[slot_q] <= 1'b1;
        vld_q             <= &(written_q | (6'b000001 << slot_q));
      end
    end
  end

  assign a2d_strt    = strt_q;
  assign a2d_chnl    = chnl_q;
  assign sweep_done  = sweep_q;
  assign timeout_err = tmo_q;
  assign pots_vld    = vld_q;
  assign lp_pot      = pot_q[SLOT_LP];
  assign b1_pot      = pot_q[SLOT_B1];
  assign b2_pot      = pot_q[SLOT_B2];
  assign b3_pot      = pot_q[SLOT_B3];
  assign hp_pot      = pot_q[SLOT_HP];
  assign vol_pot     = pot_q[SLOT_VOL];

endmodule

// File: tb/tb_pot_scan_sched.sv
// tb/tb_pot_scan_sched.sv - scoreboard bench for pot_scan_sched with a delayed-response A2D model
module tb_pot_scan_sched;

  localparam int SCAN_GAP = 1024;
  localparam int TIMEOUT  = 4096;
  localparam int A2D_LAT  = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        a2d_strt;
  logic [2:0]  a2d_chnl;
  logic        a2d_cmplt;
  logic [11:0] a2d_res;
  logic [11:0] lp_pot, b1_pot, b2_pot, b3_pot, hp_pot, vol_pot;
  logic        pots_vld, sweep_done, timeout_err;

  pot_scan_sched #(.SCAN_GAP(SCAN_GAP), .TIMEOUT(TIMEOUT), .CNT_W(13)) dut (
    .clk(clk), .rst(rst), .en(en),
    .a2d_strt(a2d_strt), .a2d_chnl(a2d_chnl),
    .a2d_cmplt(a2d_cmplt), .a2d_res(a2d_res),
    .lp_pot(lp_pot), .b1_pot(b1_pot), .b2_pot(b2_pot),
    .b3_pot(b3_pot), .hp_pot(hp_pot), .vol_pot(vol_pot),
    .pots_vld(pots_vld), .sweep_done(sweep_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    logic [11:0] val;
    int          due;
  } exp_t;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_strt = 0;
  int          n_sweep = 0;
  int          withhold = -1;
  int          exp_slot = 0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  int          pend_slot = 0;
  logic [2:0]  pend_chnl = 3'd0;
  exp_t        exp_q[$];
  logic [11:0] exp_pot [6];
  bit          exp_wr [6];
  logic [2:0]  ch_map [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] get_pot(input int idx);
    case (idx)
      0: return lp_pot;
      1: return b1_pot;
      2: return b2_pot;
      3: return b3_pot;
      4: return hp_pot;
      default: return vol_pot;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // A2D model, channel-order check and pot scoreboard in one process so the queue has a single owner
  always @(negedge clk) begin
    logic [11:0] v;
    exp_t e;
    a2d_cmplt = 1'b0;
    if (rst) begin
      pend = 1'b0;
      exp_slot = 0;
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
        exp_pot[i] = 12'h000;
        exp_wr[i]  = 1'b0;
      end
    end else begin
      while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk_eq($sformatf("pot%0d", e.slot), {20'd0, get_pot(e.slot)}, {20'd0, e.val});
      end
      if (sweep_done) n_sweep++;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          pend = 1'b0;
          a2d_cmplt = 1'b1;
          a2d_res = 12'h100 + {9'd0, pend_chnl};
`ifdef POT_SMOOTH_EN
          v = exp_wr[pend_slot] ?
              12'((({2'b00, exp_pot[pend_slot]} * 14'd3) + {2'b00, a2d_res} + 14'd2) >> 2) : a2d_res;
`else
          v = a2d_res;
`endif
          exp_pot[pend_slot] = v;
          exp_wr[pend_slot]  = 1'b1;
          e.slot = pend_slot;
          e.val  = v;
          e.due  = cyc + 2;
          exp_q.push_back(e);
        end
      end
      if (a2d_strt) begin
        n_strt++;
        chk_eq("chnl_seq", {29'd0, a2d_chnl}, {29'd0, ch_map[exp_slot]});
        if (int'(a2d_chnl) != withhold) begin
          pend = 1'b1;
          pend_cnt = A2D_LAT;
          pend_slot = exp_slot;
          pend_chnl = a2d_chnl;
        end
        exp_slot = (exp_slot == 5) ? 0 : exp_slot + 1;
      end
    end
  end

  task automatic wait_strt(input string tag, input int budget, output int t);
    int n = 0;
    do begin @(negedge clk); n++; end while (!a2d_strt && n < budget);
    chk_eq(tag, {31'd0, a2d_strt}, 32'd1);
    t = cyc;
  endtask

  task automatic wait_sweep(input string tag, input int budget, output int t);
    int n = 0;
    do begin @(negedge clk); n++; end while (!sweep_done && n < budget);
    chk_eq(tag, {31'd0, sweep_done}, 32'd1);
    t = cyc;
  endtask

  initial begin
    int t0, t1, strts;
    rst = 1'b1;
    en  = 1'b0;
    a2d_res = 12'h000;
    repeat (4) @(negedge clk);
    chk_eq("rst_lp", {20'd0, lp_pot}, 32'h0);
    chk_eq("rst_vol", {20'd0, vol_pot}, 32'h0);
    chk_eq("rst_strt", {31'd0, a2d_strt}, 32'd0);
    chk_eq("rst_chnl", {29'd0, a2d_chnl}, 32'd1);
    chk_eq("rst_vld", {31'd0, pots_vld}, 32'd0);
    chk_eq("rst_sweep", {31'd0, sweep_done}, 32'd0);
    chk_eq("rst_tmo", {31'd0, timeout_err}, 32'd0);

    // sweep 1: full round-robin with responses
    rst = 1'b0;
    en  = 1'b1;
    wait_strt("first_strt", 5, t0);
    wait_sweep("sweep1", 2000, t0);
    chk_eq("lp_101", {20'd0, lp_pot}, 32'h101);
    chk_eq("b2_104", {20'd0, b2_pot}, 32'h104);
    chk_eq("vol_107", {20'd0, vol_pot}, 32'h107);
    chk_eq("vld_sweep1", {31'd0, pots_vld}, 32'd1);
    withhold = 4;
    @(negedge clk);
    chk_eq("sweep_pulse", {31'd0, sweep_done}, 32'd0);
    chk_eq("sweep_cnt", n_sweep, 32'd1);

    // inter-sweep gap
    wait_strt("gap_strt", SCAN_GAP + 50, t1);
    chk_eq("gap_len", t1 - t0, SCAN_GAP + 1);

    // sweep 2: B2 never completes
    do wait_strt("b2_strt", 200, t0); while (a2d_strt && a2d_chnl != 3'd4);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!timeout_err && n < TIMEOUT + 100);
    end
    chk_eq("tmo_flag", {31'd0, timeout_err}, 32'd1);
    chk_eq("tmo_len", cyc - t0, TIMEOUT + 1);
    chk_eq("b2_hold", {20'd0, b2_pot}, 32'h104);
    wait_strt("after_tmo", 10, t1);
    chk_eq("after_tmo_chnl", {29'd0, a2d_chnl}, 32'd2);
    withhold = -1;
    wait_sweep("sweep2", 400, t0);
    chk_eq("tmo_sticky", {31'd0, timeout_err}, 32'd1);

    // sweep 3: drop en while B1 converts
    do wait_strt("b1_strt", SCAN_GAP + 200, t0); while (a2d_strt && a2d_chnl != 3'd0);
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (60) @(negedge clk);
    chk_eq("b1_stored", {20'd0, b1_pot}, 32'h100);
    strts = n_strt;
    repeat (1500) @(negedge clk);
    chk_eq("parked", n_strt, strts);
    en = 1'b1;
    wait_strt("resume_strt", 10, t1);
    chk_eq("resume_chnl", {29'd0, a2d_chnl}, 32'd4);

    // reset in the middle of a conversion
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_eq("arst_lp", {20'd0, lp_pot}, 32'h0);
    chk_eq("arst_b1", {20'd0, b1_pot}, 32'h0);
    chk_eq("arst_chnl", {29'd0, a2d_chnl}, 32'd1);
    chk_eq("arst_vld", {31'd0, pots_vld}, 32'd0);
    chk_eq("arst_tmo", {31'd0, timeout_err}, 32'd0);
    chk_eq("arst_strt", {31'd0, a2d_strt}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_strt("post_rst_strt", 5, t1);
    chk_eq("post_rst_chnl", {29'd0, a2d_chnl}, 32'd1);
    wait_sweep("sweep4", 2000, t0);
    chk_eq("final_lp", {20'd0, lp_pot}, 32'h101);
    chk_eq("final_vld", {31'd0, pots_vld}, 32'd1);
    chk_eq("final_tmo", {31'd0, timeout_err}, 32'd0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
